// File: rtl/serial_ripple_subtractor.sv
// rtl/serial_ripple_subtractor.sv - bit-serial unsigned subtractor, LSB first, valid/ready in and out
// Computes diff = a - b - bin one bit per clock; bout is the borrow out of the MSB.
module serial_ripple_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_diff;
  logic             r_borrow;
  logic             r_bout;
  logic [CW-1:0]    r_cnt;

  logic w_accept;
  logic w_calc;
  logic w_last;
  logic w_ai;
  logic w_bi;
  logic w_d;
  logic w_borrow_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Handshake outputs decode from the state register only.
  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next = S_CALC;
      end
      S_CALC: begin
        busy = 1'b1;
        if (w_last) w_next = S_DONE;
      end
      S_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign w_accept     = in_valid && (r_state == S_IDLE);
  assign w_calc       = (r_state == S_CALC);
  assign w_last       = w_calc && (r_cnt == LAST);
  assign w_ai         = r_a[r_cnt];
  assign w_bi         = r_b[r_cnt];
  assign w_d          = w_ai ^ w_bi ^ r_borrow;
  assign w_borrow_nxt = (~w_ai & w_bi) | (~(w_ai ^ w_bi) & r_borrow);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_diff   <= '0;
      r_borrow <= 1'b0;
      r_bout   <= 1'b0;
      r_cnt    <= '0;
    end else if (w_accept) begin
      r_a      <= a;
      r_b      <= b;
      r_borrow <= bin;
      r_cnt    <= '0;
    end else if (w_calc) begin
      r_diff[r_cnt] <= w_d;
      r_borrow      <= w_borrow_nxt;
      r_cnt         <= w_last ? '0 : r_cnt + 1'b1;
      if (w_last) r_bout <= w_borrow_nxt;
    end
  end

  assign diff = r_diff;
  assign bout = r_bout;

endmodule

// File: tb/tb_serial_ripple_subtractor.sv
// tb/tb_serial_ripple_subtractor.sv - self-checking bench for serial_ripple_subtractor
module tb_serial_ripple_subtractor;

  localparam int WIDTH = 4;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             busy;

  int checks;
  int errors;

  serial_ripple_subtractor #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic, modulo 2^WIDTH, borrow = result went negative.
  function automatic logic [WIDTH:0] model(input int av, input int bv, input int bnv);
    int r;
    r = av - bv - bnv;
    return {1'(r < 0), WIDTH'(r)};
  endfunction

  task automatic run_op(input int av, input int bv, input int bnv,
                        input int in_gap, input int out_gap, input bit noise,
                        input string tag);
    logic [WIDTH:0] exp;
    int lat;
    exp = model(av, bv, bnv);
    repeat (in_gap) @(negedge clk);
    in_valid = 1'b1;
    a = WIDTH'(av);
    b = WIDTH'(bv);
    bin = 1'(bnv);
    chk({tag, " in_ready_idle"}, in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a = WIDTH'($urandom);
    b = WIDTH'($urandom);
    bin = 1'($urandom);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    chk({tag, " latency"}, lat, WIDTH);
    chk({tag, " diff"}, diff, exp[WIDTH-1:0]);
    chk({tag, " bout"}, bout, exp[WIDTH]);
    chk({tag, " busy_done"}, busy, 1);
    chk({tag, " in_ready_done"}, in_ready, 0);
    for (int i = 0; i < out_gap; i++) begin
      out_ready = 1'b0;
      if (noise) begin
        in_valid = 1'b1;
        a = WIDTH'($urandom);
        b = WIDTH'($urandom);
        bin = 1'($urandom);
      end
      @(posedge clk);
      @(negedge clk);
      chk({tag, " held_valid"}, out_valid, 1);
      chk({tag, " held_diff"}, diff, exp[WIDTH-1:0]);
      chk({tag, " held_bout"}, bout, exp[WIDTH]);
      chk({tag, " held_in_ready"}, in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, " post_out_valid"}, out_valid, 0);
    chk({tag, " post_in_ready"}, in_ready, 1);
    chk({tag, " post_busy"}, busy, 0);
    chk({tag, " post_diff"}, diff, exp[WIDTH-1:0]);
    chk({tag, " post_bout"}, bout, exp[WIDTH]);
  endtask

  initial begin
    int seen;
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    bin       = 1'b0;
    #1;
    chk("rst0 in_ready", in_ready, 1);
    chk("rst0 out_valid", out_valid, 0);
    chk("rst0 busy", busy, 0);
    chk("rst0 diff", diff, 0);
    chk("rst0 bout", bout, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(9, 3, 0, 0, 0, 1'b0, "t2_9m3");

    // Asynchronous reset in IDLE must clear the held result without a clock edge.
    #2 rst_n = 1'b0;
    #1;
    chk("rst_idle in_ready", in_ready, 1);
    chk("rst_idle out_valid", out_valid, 0);
    chk("rst_idle busy", busy, 0);
    chk("rst_idle diff", diff, 0);
    chk("rst_idle bout", bout, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(3, 9, 0, 0, 0, 1'b0, "t3_3m9");
    run_op(0, 0, 1, 1, 0, 1'b0, "t3_0m0m1");
    run_op(15, 15, 1, 0, 1, 1'b0, "t3_15m15m1");
    run_op(12, 5, 1, 0, 6, 1'b1, "t4_backpressure");
    @(negedge clk);
    chk("t4 noise_not_accepted", busy, 0);

    // Reset two clocks into CALC aborts the operation.
    in_valid = 1'b1;
    a = 4'd9;
    b = 4'd3;
    bin = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("t5 busy_calc", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("t5 rst busy", busy, 0);
    chk("t5 rst out_valid", out_valid, 0);
    chk("t5 rst in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("t5 no_out_valid", seen, 0);
    run_op(7, 2, 0, 0, 0, 1'b0, "t5_7m2");

    for (int i = 0; i < 512; i++) begin
      run_op((i >> 5) & 15, (i >> 1) & 15, i & 1,
             int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), 1'b1, "t6_exh");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
